// File: rtl/dot_seq.sv
// dot_seq: operand sequencer for a `mac` unit of the same WIDTH.
//
// Accepts a dot-product command of cmd_len operand pairs, clears the MAC, streams
// the pairs from an upstream valid/ready source into the MAC, waits for the MAC's
// registered accumulator to settle, then returns the sum on a valid/ready port.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_len = number of operand pairs
//   op_valid/op_ready         operand handshake; op_a, op_b = operand pair
//   mac_en, mac_clr           MAC controls (registered, never high together)
//   mac_a, mac_b              MAC operands (registered, hold between loads)
//   mac_acc                   MAC accumulator output (2*WIDTH)
//   res_valid/res_ready       result handshake; res_data = dot product (2*WIDTH)
//   busy                      high whenever a command is in flight
//   stall_cnt                 (DOT_SEQ_STALL_CNT_EN only) STREAM cycles without op_valid
//
// Build option: define DOT_SEQ_STALL_CNT_EN to add the stall_cnt port and counter.

module dot_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               mac_en,
  output logic               mac_clr,
  output logic [WIDTH-1:0]   mac_a,
  output logic [WIDTH-1:0]   mac_b,
  input  logic [2*WIDTH-1:0] mac_acc,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               busy
`ifdef DOT_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain1,
    StDrain2,
    StResult
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               mac_en_q, mac_en_d;
  logic               mac_clr_q, mac_clr_d;
  logic [WIDTH-1:0]   mac_a_q, mac_a_d;
  logic [WIDTH-1:0]   mac_b_q, mac_b_d;
  logic               res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0] res_data_q, res_data_d;

  logic cmd_hs;
  logic op_hs;

  // Ready/busy decode the current state only, so they never depend on the
  // upstream valid signals.
  assign cmd_ready = (state_q == StIdle);
  assign op_ready  = (state_q == StStream) && (remaining_q != '0);
  assign busy      = (state_q != StIdle);

  assign cmd_hs = cmd_valid && cmd_ready;
  assign op_hs  = op_valid && op_ready;

  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    mac_en_d    = 1'b0;
    mac_clr_d   = 1'b0;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          if (cmd_len == '0) begin
            // Empty vector: answer immediately without disturbing the MAC.
            res_data_d  = '0;
            res_valid_d = 1'b1;
            state_d     = StResult;
          end else begin
            remaining_d = cmd_len;
            mac_clr_d   = 1'b1;
            state_d     = StClear;
          end
        end
      end
      StClear: begin
        state_d = StStream;
      end
      StStream: begin
        if (op_hs) begin
          mac_a_d     = op_a;
          mac_b_d     = op_b;
          mac_en_d    = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = StDrain1;
          end
        end
      end
      StDrain1: begin
        // The last pair's mac_en is on the wire this cycle.
        state_d = StDrain2;
      end
      StDrain2: begin
        // MAC has absorbed the last pair; its accumulator is final.
        res_data_d  = mac_acc;
        res_valid_d = 1'b1;
        state_d     = StResult;
      end
      StResult: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

`ifdef DOT_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // op_ready is always high in StStream, so a missing op_valid is an upstream stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cmd_hs) begin
      stall_cnt_d = '0;
    end else if ((state_q == StStream) && !op_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // Stall instrumentation not built.
`endif

endmodule
